uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, clocks per bit period (19200 baud at 50 MHz); legal range 4..4095.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port trmt  input  1  single-cycle request to send tx_data.
REQ-005 SHALL have port tx_data  input  8  byte to send; sampled only in the cycle trmt is high.
REQ-006 SHALL have port TX  output  1  serial line, idle high, registered output.
REQ-007 SHALL have port tx_rdy  output  1  high when a trmt will be accepted (holding register empty).
REQ-008 SHALL have port busy  output  1  high while a frame is being shifted.
REQ-009 SHALL have port tx_done  output  1  sticky completion flag.

Function
REQ-010 Frame format SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1; 10 bit periods total.
REQ-011 Each bit period SHALL last exactly BAUD_DIV clk cycles, with no gap between bits.
REQ-012 FSM SHALL have two states: IDLE, TRANSMIT.
REQ-013 IDLE + trmt at cycle N: SHALL load the frame shift register, enter TRANSMIT, and drive TX=0 from cycle N+1.
REQ-014 TRANSMIT: a bit counter (0..10) SHALL increment and the shift register SHALL shift right, filling with 1, each time the baud counter reaches BAUD_DIV-1; the baud counter SHALL then wrap to 0.
REQ-015 Frame end is the cycle the bit counter reaches 10; from that point TX SHALL return to 1 unless a back-to-back frame starts (REQ-018).
REQ-016 One-entry holding register: trmt in TRANSMIT with tx_rdy=1 SHALL capture tx_data and clear tx_rdy the next cycle.
REQ-017 trmt with tx_rdy=0 SHALL be ignored; the captured byte and the frame in flight SHALL be unaffected.
REQ-018 At frame end with the holding register full: the next frame SHALL start back-to-back, with its start bit on the cycle after the stop period ends; the holding register SHALL empty and tx_rdy SHALL go high.
REQ-019 At frame end with the holding register empty but trmt high in that same cycle: SHALL behave as REQ-018 using tx_data directly.
REQ-020 At frame end with no pending byte: SHALL go to IDLE and set tx_done the next cycle.
REQ-021 tx_done SHALL clear on any accepted trmt and SHALL NOT be set by a frame that is followed back-to-back.
REQ-022 busy SHALL equal (state == TRANSMIT).
REQ-023 tx_rdy SHALL be high in IDLE.
REQ-024 Counters SHALL be unsigned: baud counter 12 bits, bit counter 4 bits; neither SHALL exceed its terminal value.

Reset
REQ-025 rst SHALL asynchronously force: TX=1, busy=0, tx_rdy=1, tx_done=0, state IDLE, all counters 0, holding register empty.
REQ-026 rst mid-frame SHALL abort the frame immediately, with TX high within the same cycle edge; no partial-frame completion and no tx_done.
REQ-027 After rst deasserts, the first trmt SHALL behave exactly as REQ-013.

Structure
REQ-028 Package uart_pkg SHALL hold the BAUD_DIV default, FRAME_BITS=10, and the tx state typedef; it is shared with the receiver.
REQ-029 The bit-period counter SHALL be one sub-module, uart_baud_gen (enable, clear, tick output), reusable by the receiver.
REQ-030 All other logic (FSM, shift, holding register, flags) SHALL live in uart_tx.

Verification (BAUD_DIV=16 unless stated)
REQ-031 trmt with tx_data=8'hA5 from idle -> TX = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; tx_done high at cycle 161 after trmt, busy low.
REQ-032 trmt 8'h3C, then trmt 8'hC3 during bit 4 -> tx_rdy low until frame 1 ends; frame 2 starts with no idle cycle; tx_done rises only after frame 2.
REQ-033 Three trmt pulses (8'h01, 8'h02, 8'h03) during one frame -> 8'h02 is held and 8'h03 is dropped; the line carries exactly 8'h01 then 8'h02.
REQ-034 rst pulsed at bit 5 of 8'hFF -> TX=1 and busy=0 immediately; no tx_done; a subsequent trmt 8'h00 produces a clean frame.
REQ-035 trmt asserted exactly on the frame-end cycle with the holding register empty -> back-to-back frame of the new byte, tx_done stays 0.
REQ-036 Loopback with the receiver at BAUD_DIV=2604, 256 random bytes -> all received bytes match, in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period default, frame length and transmitter state type.
// Used by both the transmitter and the receiver.
package uart_pkg;
  localparam int BAUD_DIV_DEFAULT = 2604;
  localparam int FRAME_BITS       = 10;
  localparam int BAUD_CNT_W       = 12;
  localparam int BIT_CNT_W        = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    TRANSMIT = 1'b1
  } tx_state_t;

  // 8N1 frame as shifted out LSB first: start bit in bit 0, stop bit in bit 9.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 while enabled, pulses tick on the last cycle
// of each period and wraps to 0. clear holds the count at 0.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);
  logic [BAUD_CNT_W-1:0] cnt;

  assign tick = en && (cnt == BAUD_CNT_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clear || tick) cnt <= '0;
    else if (en)            cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register for back-to-back frames.
// TX comes straight from bit 0 of the frame shift register, which idles all ones.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_rdy,
  output logic       busy,
  output logic       tx_done
);
  tx_state_t                state, state_nxt;
  logic [FRAME_BITS-1:0]    shift_q, shift_nxt;
  logic [BIT_CNT_W-1:0]     bit_cnt, bit_nxt;
  logic [7:0]               hold_q, hold_nxt;
  logic                     hold_full, hold_full_nxt;
  logic                     done_q, done_nxt;
  logic                     tick;
  logic                     frame_end;

  uart_baud_gen #(.DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .en    (state == TRANSMIT),
    .clear (state == IDLE),
    .tick  (tick)
  );

  assign TX      = shift_q[0];
  assign tx_rdy  = ~hold_full;
  assign busy    = (state == TRANSMIT);
  assign tx_done = done_q;

  // Last tick of the stop bit: the bit counter would reach FRAME_BITS here.
  assign frame_end = (state == TRANSMIT) && tick &&
                     (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_q;
    bit_nxt       = bit_cnt;
    hold_nxt      = hold_q;
    hold_full_nxt = hold_full;
    done_nxt      = done_q;
    case (state)
      IDLE: begin
        if (trmt) begin
          state_nxt = TRANSMIT;
          shift_nxt = make_frame(tx_data);
          bit_nxt   = '0;
          done_nxt  = 1'b0;
        end
      end
      TRANSMIT: begin
        if (frame_end) begin
          bit_nxt = '0;
          if (hold_full) begin
            shift_nxt     = make_frame(hold_q);
            hold_full_nxt = 1'b0;
          end else if (trmt) begin
            shift_nxt = make_frame(tx_data);
            done_nxt  = 1'b0;
          end else begin
            shift_nxt = '1;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          if (tick) begin
            shift_nxt = {1'b1, shift_q[FRAME_BITS-1:1]};
            bit_nxt   = bit_cnt + 1'b1;
          end
          // A trmt while the holding register is full is simply dropped.
          if (trmt && !hold_full) begin
            hold_nxt      = tx_data;
            hold_full_nxt = 1'b1;
            done_nxt      = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_q   <= '1;
      bit_cnt   <= '0;
      hold_q    <= '0;
      hold_full <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_q   <= shift_nxt;
      bit_cnt   <= bit_nxt;
      hold_q    <= hold_nxt;
      hold_full <= hold_full_nxt;
      done_q    <= done_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at BAUD_DIV=16: a line monitor decodes every frame
// and compares it against a scoreboard of bytes the bench expects to be accepted.
module tb_uart_tx;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       TX, tx_rdy, busy, tx_done;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] sb[$];
  int         starts[$];

  uart_tx #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_rdy  (tx_rdy),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive a one-cycle trmt pulse; returns the cycle number in which trmt was high.
  task automatic send(input logic [7:0] b, output int n);
    tx_data = b;
    trmt    = 1'b1;
    n       = cyc;
    @(negedge clk);
    trmt    = 1'b0;
  endtask

  // Line monitor: 10 bits of BD samples each, every sample in a bit must agree.
  initial begin : monitor
    bit          active = 0;
    bit          bad = 0;
    int          idx = 0;
    logic [9:0]  bits = '0;
    logic [31:0] exp_v;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else begin
        if (!active && TX == 1'b0) begin
          active = 1;
          idx    = 0;
          bad    = 0;
          starts.push_back(cyc);
        end
        if (active) begin
          if (idx % BD == 0) bits[idx / BD] = TX;
          else if (TX !== bits[idx / BD]) bad = 1;
          idx++;
          if (idx == 10 * BD) begin
            active = 0;
            if (sb.size() > 0) exp_v = {22'd0, 1'b0, 1'b1, sb.pop_front(), 1'b0};
            else               exp_v = 32'hFFFF_FFFF;
            check("frame", {22'd0, bad, bits}, exp_v);
          end
        end
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  initial begin : stim
    vec_t vecs[5];
    int   n, m;
    logic [7:0] rb[12];

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};

    // Reset state
    @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_busy", busy, 0);
    check("rst_rdy", tx_rdy, 1);
    check("rst_done", tx_done, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_until(cyc + 3);

    // Single frames from idle, each bit checked mid-period
    foreach (vecs[v]) begin
      starts.delete();
      sb.push_back(vecs[v].data);
      send(vecs[v].data, n);
      for (int b = 0; b < 10; b++) begin
        wait_until(n + 1 + BD * b + BD / 2);
        check($sformatf("bit%0d_of_%02h", b, vecs[v].data), TX, vecs[v].frame[b]);
      end
      wait_until(n + 10 * BD);
      check("busy_at_end", busy, 1);
      check("done_early", tx_done, 0);
      wait_until(n + 10 * BD + 1);
      check("done_set", tx_done, 1);
      check("busy_clear", busy, 0);
      check("rdy_idle", tx_rdy, 1);
      check("start_latency", starts.size() > 0 ? starts[0] : -1, n + 1);
      wait_until(cyc + 5);
    end

    // Holding register: second byte during bit 4, back-to-back
    starts.delete();
    sb.push_back(8'h3C);
    send(8'h3C, n);
    wait_until(n + 1 + BD * 4 + 3);
    check("rdy_before_hold", tx_rdy, 1);
    sb.push_back(8'hC3);
    send(8'hC3, m);
    check("rdy_held", tx_rdy, 0);
    wait_until(n + 10 * BD - 1);
    check("rdy_still_low", tx_rdy, 0);
    wait_until(n + 10 * BD + 1);
    check("rdy_after_b2b", tx_rdy, 1);
    check("busy_b2b", busy, 1);
    check("done_not_set_b2b", tx_done, 0);
    wait_until(n + 20 * BD + 1);
    check("done_after_f2", tx_done, 1);
    check("b2b_gap", starts.size() == 2 ? starts[1] - starts[0] : -1, 10 * BD);
    wait_until(cyc + 5);

    // Three pulses in one frame: third is dropped
    starts.delete();
    sb.push_back(8'h01);
    send(8'h01, n);
    wait_until(n + 20);
    sb.push_back(8'h02);
    send(8'h02, m);
    wait_until(n + 40);
    check("rdy_full", tx_rdy, 0);
    send(8'h03, m);
    wait_until(n + 20 * BD + 1);
    check("done_two_frames", tx_done, 1);
    wait_until(n + 30 * BD);
    check("frames_drop", starts.size(), 2);
    check("sb_empty_drop", sb.size(), 0);

    // Reset mid-frame at bit 5 of 8'hFF
    starts.delete();
    sb.push_back(8'hFF);
    send(8'hFF, n);
    wait_until(n + 1 + BD * 5 + 5);
    check("pre_rst_tx", TX, 1);
    rst = 1'b1;
    #1;
    check("rst_async_tx", TX, 1);
    check("rst_async_busy", busy, 0);
    check("rst_async_rdy", tx_rdy, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    starts.delete();
    wait_until(cyc + 200);
    check("no_done_after_rst", tx_done, 0);
    check("no_frame_after_rst", starts.size(), 0);
    sb.push_back(8'h00);
    send(8'h00, n);
    wait_until(n + 10 * BD + 1);
    check("post_rst_start", starts.size() > 0 ? starts[0] : -1, n + 1);
    check("post_rst_done", tx_done, 1);
    check("post_rst_sb", sb.size(), 0);
    wait_until(cyc + 5);

    // trmt exactly on the frame-end cycle with holding register empty
    starts.delete();
    sb.push_back(8'h5A);
    send(8'h5A, n);
    wait_until(n + 10 * BD);
    sb.push_back(8'h96);
    send(8'h96, m);
    check("fe_done_stays", tx_done, 0);
    check("fe_busy", busy, 1);
    check("fe_rdy", tx_rdy, 1);
    wait_until(n + 20 * BD + 1);
    check("fe_done_after", tx_done, 1);
    check("fe_gap", starts.size() == 2 ? starts[1] - starts[0] : -1, 10 * BD);
    wait_until(cyc + 5);

    // Random back-to-back stream through the holding register
    starts.delete();
    foreach (rb[k]) rb[k] = 8'($urandom_range(0, 255));
    sb.push_back(rb[0]);
    send(rb[0], n);
    for (int k = 1; k < 12; k++) begin
      wait_until(n + 1 + 10 * BD * (k - 1) + 30);
      check($sformatf("rand_rdy%0d", k), tx_rdy, 1);
      sb.push_back(rb[k]);
      send(rb[k], m);
    end
    wait_until(n + 1 + 10 * BD * 12 + 5);
    check("rand_frames", starts.size(), 12);
    check("rand_sb_empty", sb.size(), 0);
    begin
      int bad_gaps = 0;
      for (int k = 1; k < starts.size(); k++)
        if (starts[k] - starts[k-1] != 10 * BD) bad_gaps++;
      check("rand_gaps", bad_gaps, 0);
    end
    check("rand_done", tx_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
